// File: rtl/pipes.sv
// Shared pipeline definitions: memory-stage FSM states, access-size encodings and size helpers.
package pipes;

    typedef enum logic [2:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT,
        LSU_DONE,
        LSU_DRAIN
    } lsu_state_t;

    localparam logic [2:0] LSU_SZ1 = 3'd0;
    localparam logic [2:0] LSU_SZ2 = 3'd1;
    localparam logic [2:0] LSU_SZ4 = 3'd2;
    localparam logic [2:0] LSU_SZ8 = 3'd3;

    function automatic logic [2:0] lsu_clamp_size(input logic [2:0] sz, input logic [2:0] max_sz);
        return (sz > max_sz) ? max_sz : sz;
    endfunction

    function automatic logic [3:0] lsu_nbytes(input logic [2:0] sz);
        case (sz)
            LSU_SZ1: return 4'd1;
            LSU_SZ2: return 4'd2;
            LSU_SZ4: return 4'd4;
            LSU_SZ8: return 4'd8;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: store strobe/data shift, load extract with sign/zero extension.
// Purely combinational, zero latency, no handshake.
module lsu_align
    import pipes::*;
#(
    parameter  int DATA_W = 64,
    localparam int BYTES  = DATA_W / 8,
    localparam int OFF_W  = $clog2(BYTES)
) (
    input  logic [OFF_W-1:0]  i_st_off,
    input  logic [2:0]        i_st_size,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [BYTES-1:0]  o_strobe,
    output logic [DATA_W-1:0] o_wdata,
    input  logic [OFF_W-1:0]  i_ld_off,
    input  logic [2:0]        i_ld_size,
    input  logic              i_ld_zext,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [DATA_W-1:0] o_ld_data
);

    logic [BYTES-1:0]  w_st_bmask;
    logic [DATA_W-1:0] w_ld_sh;
    logic [DATA_W-1:0] w_ld_mask;
    logic [DATA_W-1:0] w_ld_top;
    logic              w_ld_neg;

    // Shifts past the word end fall off, so misaligned lanes are silently dropped.
    assign w_st_bmask = ~({BYTES{1'b1}} << lsu_nbytes(i_st_size));
    assign o_strobe   = w_st_bmask << i_st_off;
    assign o_wdata    = i_wdata << {i_st_off, 3'b000};

    assign w_ld_sh   = i_rdata >> {i_ld_off, 3'b000};
    assign w_ld_mask = ~({DATA_W{1'b1}} << {lsu_nbytes(i_ld_size), 3'b000});
    // Isolate the MSB of the access to pick up its sign without a variable index.
    assign w_ld_top  = w_ld_mask & ~(w_ld_mask >> 1);
    assign w_ld_neg  = |(w_ld_sh & w_ld_top);
    assign o_ld_data = (i_ld_zext | ~w_ld_neg) ? (w_ld_sh & w_ld_mask) : (w_ld_sh | ~w_ld_mask);

endmodule

// File: rtl/lsu_stage.sv
// Memory-stage load/store unit: registered bus request 1 cycle after issue, done 1 cycle after data_ok;
// stalls the pipe until done, flush drains in-flight data. LSU_MISALIGN_EXC_EN traps misaligned accesses.
module lsu_stage
    import pipes::*;
#(
    parameter  int DATA_W = 64,
    parameter  int ADDR_W = 64,
    localparam int BYTES  = DATA_W / 8,
    localparam int OFF_W  = $clog2(BYTES)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_in_valid,
    input  logic              i_in_read,
    input  logic              i_in_write,
    input  logic [ADDR_W-1:0] i_in_addr,
    input  logic [DATA_W-1:0] i_in_wdata,
    input  logic [2:0]        i_in_size,
    input  logic              i_in_zext,
    input  logic              i_pipe_adv,
    input  logic              i_flush,
    output logic              o_req_valid,
    output logic [ADDR_W-1:0] o_req_addr,
    output logic [2:0]        o_req_size,
    output logic [BYTES-1:0]  o_req_strobe,
    output logic [DATA_W-1:0] o_req_data,
    input  logic              i_resp_addr_ok,
    input  logic              i_resp_data_ok,
    input  logic [DATA_W-1:0] i_resp_data,
    output logic              o_stall,
    output logic [DATA_W-1:0] o_ld_data,
    output logic              o_done,
    output logic              o_misalign
);

    localparam logic [2:0] MAX_SZ = 3'(OFF_W);

    lsu_state_t        r_state;
    logic              r_req_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_size;
    logic              r_zext;
    logic [BYTES-1:0]  r_strobe;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_ld_data;
    logic              r_done;

    logic              w_mem;
    logic              w_mis;
    logic              w_accept;
    logic [2:0]        w_size;
    logic [BYTES-1:0]  w_st_strobe;
    logic [DATA_W-1:0] w_st_data;
    logic [DATA_W-1:0] w_ld_data;

    assign w_mem  = i_in_valid & (i_in_read | i_in_write);
    assign w_size = lsu_clamp_size(i_in_size, MAX_SZ);

`ifdef LSU_MISALIGN_EXC_EN
    logic [OFF_W-1:0] w_amask;
    assign w_amask    = OFF_W'(lsu_nbytes(w_size) - 4'd1);
    assign w_mis      = |(i_in_addr[OFF_W-1:0] & w_amask);
    assign o_misalign = i_reset & w_mem & w_mis & ~i_flush & (r_state == LSU_IDLE);
`else
    assign w_mis      = 1'b0;
    assign o_misalign = 1'b0;
`endif

    assign w_accept = w_mem & ~i_flush & ~w_mis;
    assign o_stall  = i_reset & w_mem & ~i_flush & (r_state != LSU_DONE)
                    & ~((r_state == LSU_IDLE) & w_mis);

    lsu_align #(.DATA_W(DATA_W)) u_align (
        .i_st_off  (i_in_addr[OFF_W-1:0]),
        .i_st_size (w_size),
        .i_wdata   (i_in_wdata),
        .o_strobe  (w_st_strobe),
        .o_wdata   (w_st_data),
        .i_ld_off  (r_addr[OFF_W-1:0]),
        .i_ld_size (r_size),
        .i_ld_zext (r_zext),
        .i_rdata   (i_resp_data),
        .o_ld_data (w_ld_data)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= LSU_IDLE;
            r_req_valid <= 1'b0;
            r_addr      <= '0;
            r_size      <= '0;
            r_zext      <= 1'b0;
            r_strobe    <= '0;
            r_wdata     <= '0;
            r_ld_data   <= '0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                LSU_IDLE: if (w_accept) begin
                    r_state     <= LSU_REQ;
                    r_req_valid <= 1'b1;
                    r_addr      <= i_in_addr;
                    r_size      <= w_size;
                    r_zext      <= i_in_zext;
                    r_strobe    <= i_in_write ? w_st_strobe : '0;
                    r_wdata     <= i_in_write ? w_st_data : '0;
                end
                LSU_REQ: if (i_flush) begin
                    r_req_valid <= 1'b0;
                    // Once the address is accepted the bus owes a data beat that must be drained.
                    r_state     <= (i_resp_addr_ok & ~i_resp_data_ok) ? LSU_DRAIN : LSU_IDLE;
                end else if (i_resp_addr_ok) begin
                    r_req_valid <= 1'b0;
                    if (i_resp_data_ok) begin
                        r_state   <= LSU_DONE;
                        r_done    <= 1'b1;
                        r_ld_data <= w_ld_data;
                    end else begin
                        r_state <= LSU_WAIT;
                    end
                end
                LSU_WAIT: if (i_resp_data_ok) begin
                    if (i_flush) begin
                        r_state <= LSU_IDLE;
                    end else begin
                        r_state   <= LSU_DONE;
                        r_done    <= 1'b1;
                        r_ld_data <= w_ld_data;
                    end
                end else if (i_flush) begin
                    r_state <= LSU_DRAIN;
                end
                LSU_DRAIN: if (i_resp_data_ok) begin
                    r_state <= LSU_IDLE;
                end
                LSU_DONE: if (i_pipe_adv | i_flush) begin
                    r_state <= LSU_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state     <= LSU_IDLE;
                    r_req_valid <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    assign o_req_valid  = r_req_valid;
    assign o_req_addr   = r_addr;
    assign o_req_size   = r_size;
    assign o_req_strobe = r_strobe;
    assign o_req_data   = r_wdata;
    assign o_ld_data    = r_ld_data;
    assign o_done       = r_done;

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage (DATA_W=64) with a request/load-result scoreboard.
module tb_lsu_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_read, in_write, in_zext, pipe_adv, flush;
    logic [63:0] in_addr, in_wdata, resp_data;
    logic [2:0]  in_size;
    logic        resp_addr_ok, resp_data_ok;
    logic        req_valid, stall, done, misalign;
    logic [63:0] req_addr, req_data, ld_data;
    logic [2:0]  req_size;
    logic [7:0]  req_strobe;

    typedef struct {
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
        bit          wr;
    } req_t;

    req_t        exp_req[$];
    logic [63:0] exp_ld[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    logic [63:0] last_ld = 64'h0;
    logic [7:0]  last_strobe = 8'h0;
    logic [63:0] last_data = 64'h0;

    always #5 clk = ~clk;

    lsu_stage #(.DATA_W(64), .ADDR_W(64)) u_dut (
        .i_clk          (clk),
        .i_reset        (rst_n),
        .i_in_valid     (in_valid),
        .i_in_read      (in_read),
        .i_in_write     (in_write),
        .i_in_addr      (in_addr),
        .i_in_wdata     (in_wdata),
        .i_in_size      (in_size),
        .i_in_zext      (in_zext),
        .i_pipe_adv     (pipe_adv),
        .i_flush        (flush),
        .o_req_valid    (req_valid),
        .o_req_addr     (req_addr),
        .o_req_size     (req_size),
        .o_req_strobe   (req_strobe),
        .o_req_data     (req_data),
        .i_resp_addr_ok (resp_addr_ok),
        .i_resp_data_ok (resp_data_ok),
        .i_resp_data    (resp_data),
        .o_stall        (stall),
        .o_ld_data      (ld_data),
        .o_done         (done),
        .o_misalign     (misalign)
    );

    function automatic int m_nb(input logic [2:0] sz);
        return 1 << ((sz > 3'd3) ? 3 : int'(sz));
    endfunction

    function automatic logic [7:0] m_strobe(input logic [63:0] a, input logic [2:0] sz);
        logic [7:0] s;
        int off;
        s = 8'h0;
        off = int'(a[2:0]);
        for (int b = 0; b < 8; b++) s[b] = (b >= off) && (b < off + m_nb(sz));
        return s;
    endfunction

    function automatic logic [63:0] m_wdata(input logic [63:0] a, input logic [63:0] wd);
        logic [63:0] d;
        int off;
        d = 64'h0;
        off = int'(a[2:0]);
        for (int b = 0; b < 8; b++) if (b >= off) d[b*8 +: 8] = wd[(b-off)*8 +: 8];
        return d;
    endfunction

    function automatic logic [63:0] m_ld(input logic [63:0] rd, input logic [63:0] a,
                                         input logic [2:0] sz, input bit zx);
        logic [63:0] r;
        int off;
        int nb;
        r = 64'h0;
        off = int'(a[2:0]);
        nb = m_nb(sz);
        for (int b = 0; b < nb; b++) if (off + b < 8) r[b*8 +: 8] = rd[(off+b)*8 +: 8];
        if (!zx && r[nb*8-1]) for (int b = nb; b < 8; b++) r[b*8 +: 8] = 8'hFF;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input bit wr, input logic [63:0] a, input logic [63:0] wd,
                           input logic [2:0] sz, input bit zx, input logic [63:0] rd, input bit push_ld);
        req_t e;
        in_valid = 1'b1; in_read = !wr; in_write = wr;
        in_addr = a; in_wdata = wd; in_size = sz; in_zext = zx;
        e.addr = a; e.size = sz; e.wr = wr;
        e.strobe = wr ? m_strobe(a, sz) : 8'h0;
        e.data = m_wdata(a, wd);
        exp_req.push_back(e);
        if (!wr && push_ld) exp_ld.push_back(m_ld(rd, a, sz, zx));
    endtask

    task automatic check_req();
        req_t e;
        chk("req_expected", 64'(exp_req.size() != 0), 64'h1);
        if (exp_req.size() != 0) begin
            e = exp_req.pop_front();
            last_strobe = req_strobe;
            last_data = req_data;
            chk("req_addr", req_addr, e.addr);
            chk("req_strobe", 64'(req_strobe), 64'(e.strobe));
            if (e.wr) chk("req_data", req_data, e.data);
            if (e.size <= 3'd3) chk("req_size", 64'(req_size), 64'(e.size));
        end
    endtask

    // Drives the bus acks for the access presented this cycle and checks latency, stall and result.
    task automatic run(input int a_lat, input int d_lat, input logic [63:0] rd, input bit is_ld);
        int cyc, st_cnt, rv_cnt;
        bit seen, got;
        logic [63:0] e;
        cyc = 0; st_cnt = 0; rv_cnt = 0; seen = 0; got = 0;
        while (!got && cyc < 40) begin
            resp_addr_ok = (cyc == a_lat);
            resp_data_ok = (cyc == d_lat);
            resp_data = (cyc == d_lat) ? rd : 64'h0;
            @(negedge clk);
            if (done) got = 1;
            else begin
                st_cnt += int'(stall);
                rv_cnt += int'(req_valid);
                if (req_valid && !seen) begin
                    seen = 1;
                    check_req();
                end
                step();
                cyc++;
            end
        end
        chk("done_seen", 64'(got), 64'h1);
        chk("done_cycle", 64'(cyc), 64'(d_lat + 1));
        chk("stall_cycles", 64'(st_cnt), 64'(d_lat + 1));
        chk("req_valid_cycles", 64'(rv_cnt), 64'(a_lat));
        chk("stall_at_done", 64'(stall), 64'h0);
        if (is_ld) begin
            chk("ld_expected", 64'(exp_ld.size() != 0), 64'h1);
            if (exp_ld.size() != 0) begin
                e = exp_ld.pop_front();
                chk("ld_data", ld_data, e);
                last_ld = e;
            end
        end
        resp_addr_ok = 0; resp_data_ok = 0; resp_data = 64'h0;
        in_valid = 0; in_read = 0; in_write = 0; pipe_adv = 1;
        step();
        pipe_adv = 0;
        @(negedge clk);
        chk("done_clear", 64'(done), 64'h0);
        step();
    endtask

    initial begin
        int dn, rv;
        rst_n = 0; in_valid = 0; in_read = 0; in_write = 0; in_zext = 0;
        pipe_adv = 0; flush = 0; in_addr = 0; in_wdata = 0; in_size = 0;
        resp_addr_ok = 0; resp_data_ok = 0; resp_data = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", 64'(req_valid), 64'h0);
        chk("rst_req_addr", req_addr, 64'h0);
        chk("rst_req_data", req_data, 64'h0);
        chk("rst_misc", 64'({req_size, req_strobe, stall, done, misalign}), 64'h0);
        chk("rst_ld_data", ld_data, 64'h0);
        rst_n = 1;
        step();

        // Signed byte load, same-cycle acks.
        present(0, 64'h8000_0003, 64'h0, 3'd0, 0, 64'h0000_0000_8000_0000, 1);
        run(1, 1, 64'h0000_0000_8000_0000, 1);
        chk("ld_byte_value", ld_data, 64'hFFFF_FFFF_FFFF_FF80);

        present(1, 64'h1006, 64'hBEEF, 3'd1, 0, 64'h0, 0);
        run(1, 1, 64'h0, 0);
        chk("st_half_strobe", 64'(last_strobe), 64'hC0);
        chk("st_half_data", last_data, 64'hBEEF_0000_0000_0000);

        present(0, 64'h2004, 64'h0, 3'd2, 0, 64'h9234_5678_0000_0000, 1);
        run(1, 4, 64'h9234_5678_0000_0000, 1);
        chk("ld_word_value", ld_data, 64'hFFFF_FFFF_9234_5678);

        present(0, 64'h3002, 64'h0, 3'd1, 1, 64'h0000_0000_8001_0000, 1);
        run(2, 3, 64'h0000_0000_8001_0000, 1);

        present(1, 64'h5000, 64'h0123_4567_89AB_CDEF, 3'd3, 0, 64'h0, 0);
        run(1, 2, 64'h0, 0);

        present(0, 64'h6000, 64'h0, 3'd7, 0, 64'hF000_0000_0000_0001, 1);
        run(1, 1, 64'hF000_0000_0000_0001, 1);

        present(1, 64'h7007, 64'h1234_5678_9ABC_DEA5, 3'd0, 0, 64'h0, 0);
        run(3, 3, 64'h0, 0);

        // Flush in REQ before addr_ok drops the request.
        present(0, 64'h9000, 64'h0, 3'd3, 0, 64'h0, 0);
        step();
        flush = 1;
        @(negedge clk);
        chk("frq_req_valid", 64'(req_valid), 64'h1);
        check_req();
        chk("frq_stall", 64'(stall), 64'h0);
        step();
        flush = 0; in_valid = 0; in_read = 0;
        @(negedge clk);
        chk("frq_req_drop", 64'(req_valid), 64'h0);
        chk("frq_done", 64'(done), 64'h0);
        step();
        present(0, 64'h9008, 64'h0, 3'd1, 0, 64'h0000_0000_0000_7FFF, 1);
        run(1, 1, 64'h0000_0000_0000_7FFF, 1);

        // Flush in WAIT, data arrives two cycles later and must be discarded.
        present(0, 64'hA000, 64'h0, 3'd3, 0, 64'h0, 0);
        dn = 0;
        step();
        resp_addr_ok = 1;
        @(negedge clk);
        chk("fw_req_valid", 64'(req_valid), 64'h1);
        check_req();
        step();
        resp_addr_ok = 0; flush = 1;
        @(negedge clk);
        chk("fw_stall", 64'(stall), 64'h0);
        dn += int'(done);
        step();
        flush = 0; in_valid = 0; in_read = 0;
        @(negedge clk);
        dn += int'(done);
        step();
        resp_data_ok = 1; resp_data = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clk);
        dn += int'(done);
        step();
        resp_data_ok = 0; resp_data = 64'h0;
        @(negedge clk);
        dn += int'(done);
        chk("fw_no_done", 64'(dn), 64'h0);
        chk("fw_ld_kept", ld_data, last_ld);
        chk("fw_req_idle", 64'(req_valid), 64'h0);
        step();
        present(0, 64'hA001, 64'h0, 3'd0, 1, 64'h0000_0000_0000_C300, 1);
        run(1, 1, 64'h0000_0000_0000_C300, 1);

        // Reset during REQ clears everything at once; a fresh access then completes.
        present(0, 64'h8008, 64'h0, 3'd3, 0, 64'h0, 0);
        step();
        @(negedge clk);
        chk("rmid_req_valid", 64'(req_valid), 64'h1);
        check_req();
        #1 rst_n = 0;
        #1;
        chk("rmid_req_drop", 64'(req_valid), 64'h0);
        chk("rmid_req_addr", req_addr, 64'h0);
        chk("rmid_misc", 64'({req_size, req_strobe, stall, done, misalign}), 64'h0);
        chk("rmid_ld_data", ld_data, 64'h0);
        in_valid = 0; in_read = 0;
        step();
        @(negedge clk);
        rst_n = 1;
        step();
        present(0, 64'h8010, 64'h0, 3'd3, 0, 64'h8877_6655_4433_2211, 1);
        run(1, 1, 64'h8877_6655_4433_2211, 1);

`ifdef LSU_MISALIGN_EXC_EN
        in_valid = 1; in_read = 1; in_addr = 64'hB002; in_size = 3'd2; in_zext = 0;
        rv = 0;
        @(negedge clk);
        chk("mis_pulse", 64'(misalign), 64'h1);
        chk("mis_stall", 64'(stall), 64'h0);
        rv += int'(req_valid);
        step();
        in_valid = 0; in_read = 0;
        @(negedge clk);
        chk("mis_clear", 64'(misalign), 64'h0);
        for (int i = 0; i < 3; i++) begin
            rv += int'(req_valid);
            step();
            @(negedge clk);
        end
        chk("mis_no_req", 64'(rv), 64'h0);
        step();
        present(0, 64'hB004, 64'h0, 3'd2, 1, 64'h8000_0001_0000_0000, 1);
        run(1, 1, 64'h8000_0001_0000_0000, 1);
`else
        rv = 0;
        present(1, 64'hB006, 64'h1122_3344, 3'd2, 0, 64'h0, 0);
        #3;
        rv += int'(misalign);
        run(1, 1, 64'h0, 0);
        rv += int'(misalign);
        chk("mis_tied_low", 64'(rv), 64'h0);
        chk("mis_st_strobe", 64'(last_strobe), 64'hC0);
        chk("mis_st_data", last_data, 64'h3344_0000_0000_0000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lsu_stage.md
# lsu_stage

Parametrised load/store unit for the memory stage of the in-order pipeline. It takes the executed access (address, data, size, sign mode) and drives a registered request on the data bus with a valid/addr_ok/data_ok handshake. It aligns store data and byte strobes to `DATA_W` lanes and extracts and extends load data into a registered result. It stalls the pipeline until the access completes, and it supports a flush that discards an in-flight access safely.

## Interface
- `DATA_W`, 64, bus and register width; legal values are 32 and 64.
- `ADDR_W`, 64, address width.
- `clk`  in  1  sole clock; every register updates on the rising edge.
- `reset`  in  1  asynchronous, active-low: asserted when 0, released synchronously by the integrator.
- `in_valid`  in  1  the stage holds a valid instruction.
- `in_read` / `in_write`  in  1 each  load / store; never both 1.
- `in_addr`  in  ADDR_W  effective address.
- `in_wdata`  in  DATA_W  store data, LSB-aligned.
- `in_size`  in  3  access size as log2(bytes): 0=1B, 1=2B, 2=4B, 3=8B.
- `in_zext`  in  1  zero-extend the load result; 0 means sign-extend.
- `pipe_adv`  in  1  the downstream stage accepts this cycle.
- `flush`  in  1  kill the current access.
- `req_valid`  out  1  bus request valid.
- `req_addr`  out  ADDR_W  bus address.
- `req_size`  out  3  bus size.
- `req_strobe`  out  DATA_W/8  byte enables; 0 on loads.
- `req_data`  out  DATA_W  lane-shifted store data.
- `resp_addr_ok` / `resp_data_ok`  in  1 each  bus handshake.
- `resp_data`  in  DATA_W  raw bus read word.
- `stall`  out  1  the pipeline must hold.
- `ld_data`  out  DATA_W  extended load result.
- `done`  out  1  access completed; `ld_data` is valid.
- `misalign`  out  1  misaligned-access exception (only when the macro is enabled).

## Operation
- Derived values: `BYTES=DATA_W/8`, `OFF_W=log2(BYTES)`, `off=in_addr[OFF_W-1:0]`.
- The FSM has five states: IDLE, REQ, WAIT, DONE, DRAIN.
- IDLE: on `in_valid & (in_read|in_write) & ~flush`, register the request fields and go to REQ.
- REQ: `req_valid=1`.
  - `addr_ok & data_ok` goes to DONE.
  - `addr_ok` alone goes to WAIT.
  - `flush` without `addr_ok` goes to IDLE and drops the request.
- WAIT: `data_ok` goes to DONE. `flush` goes to DRAIN.
- DRAIN: wait for `data_ok`, discard the data, go to IDLE. `done` stays 0.
- DONE: `done=1`. On `pipe_adv|flush`, go to IDLE.
- Store path:
  - `req_data = in_wdata << (off*8)`, truncated to DATA_W.
  - `req_strobe = ((1<<(1<<size))-1) << off`, truncated to BYTES.
- Load path:
  - `resp_data >> (off*8)`, masked to the access size, then sign- or zero-extended per `in_zext`.
  - The result is captured into `ld_data` on `data_ok`.
- Size `in_size > OFF_W` is clamped to the full word.
- Stall: `stall = in_valid & (in_read|in_write) & (state!=DONE)`. It is forced to 0 when `flush` is asserted.
- Non-memory instructions pass through with `stall=0`.

## Timing
- Reset values: state IDLE, and all outputs 0 (`req_*`, `stall` register part, `ld_data`, `done`, `misalign`).
- Request fields are registered. `req_valid` rises 1 cycle after the access is presented in IDLE.
- `req_*` hold stable while in REQ until `addr_ok` is seen.
- Minimum latency with same-cycle `addr_ok & data_ok`:
  - access presented at cycle 0;
  - `req_valid` at cycle 1;
  - `done=1` and `stall=0` at cycle 2.
- `req_valid` drops in the cycle after `addr_ok`.
- `done` stays high until `pipe_adv`. The next access may start on the cycle after DONE→IDLE.
- `flush` in the same cycle as `addr_ok` in REQ goes to DRAIN.
- `flush` in the same cycle as `data_ok` in WAIT goes to IDLE with no `done`.
- Reset asserted mid-operation returns to IDLE immediately. The bus side is reset in lockstep.

## Configuration
- `LSU_MISALIGN_EXC_EN` defined:
  - an access with `off % (1<<size) != 0` issues no bus request;
  - `misalign=1` for exactly 1 cycle while in IDLE;
  - `stall=0`, and the FSM stays in IDLE.
- `LSU_MISALIGN_EXC_EN` undefined:
  - `misalign` is tied to 0;
  - a misaligned access is issued unchanged, and lanes past DATA_W are silently dropped.

## Structure
- The shared `pipes` package gains `lsu_state_t` (the five-state enum) and the size encoding constants `LSU_SZ1`, `LSU_SZ2`, `LSU_SZ4` and `LSU_SZ8`.
- One sub-module, `lsu_align`, is combinational and parametrised by `DATA_W`. It generates strobe and store-data alignment and performs load extraction and extension.

## Test plan
- DATA_W=64, load byte at `0x80000003`, `resp_data=0x00000000_80000000`, `in_zext=0`, same-cycle ok → `done` at cycle 2, `ld_data=0xFFFFFFFFFFFFFF80`.
- DATA_W=64, store half `0xBEEF` at offset 6 → `req_strobe=0xC0`, `req_data=0xBEEF0000_00000000`.
- DATA_W=32, load word, `addr_ok` at cycle 1 and `data_ok` at cycle 4 → `stall=1` for cycles 0–4, `done` at cycle 5.
- `flush` in WAIT, `data_ok` 2 cycles later → DRAIN, `done` never asserts, IDLE after `data_ok`.
- With `LSU_MISALIGN_EXC_EN`, word load at offset 2 → `misalign=1` for 1 cycle, `req_valid` stays 0.
- Reset pulled low during REQ → all outputs 0 and IDLE immediately; a fresh access after release completes normally.
